vram_wr_arbiter: RTL

VRAM_WR_ARBITER -- requirements
Module: vram_wr_arbiter

---
 rtl/vram_wr_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/vram_wr_arbiter.sv
// vram_wr_arbiter: two-requester round-robin write arbiter in front of a
// single-port VRAM write port, with an optional full-RAM zero-fill engine.
// Optional feature macro: VRAM_ARB_CLEAR_EN (enables the CLEAR state and the
// zero-fill engine; without it clr_start is ignored and clr_busy/clr_done are 0).
module vram_wr_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din
);

  // prio=0: requester 0 wins a tie; prio=1: requester 1 wins a tie
  logic prio;
  logic arb_en;
  logic go_clear;
  logic in_clear;
  logic grant0, grant1;

`ifdef VRAM_ARB_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;
  // Counter is one bit wider than the address so the final address (all ones)
  // is written before the terminal count is seen, without wrapping.
  localparam logic [ADDR_WIDTH:0] LAST_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t              state;
  logic [ADDR_WIDTH:0] clr_cnt;

  assign in_clear = (state == CLEAR);
  assign go_clear = (state == IDLE) && clr_start;
`else
  logic unused_clr_start;

  assign unused_clr_start = clr_start;
  assign in_clear         = 1'b0;
  assign go_clear         = 1'b0;
  assign clr_busy         = 1'b0;
  assign clr_done         = 1'b0;
`endif

  // Arbitration is open only out of reset, in IDLE, and when no clear is starting
  assign arb_en     = reset_n && !in_clear && !go_clear;
  assign grant0     = arb_en && req0_valid && (!req1_valid || !prio);
  assign grant1     = arb_en && req1_valid && (!req0_valid || prio);
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // FSM, priority pointer and registered RAM write port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio     <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
`ifdef VRAM_ARB_CLEAR_EN
      state    <= IDLE;
      clr_cnt  <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
`endif
    end else begin
      ram_we <= grant0 || grant1;
      if (grant0) begin
        ram_addr <= req0_addr;
        ram_din  <= req0_data;
        prio     <= 1'b1;
      end else if (grant1) begin
        ram_addr <= req1_addr;
        ram_din  <= req1_data;
        prio     <= 1'b0;
      end
`ifdef VRAM_ARB_CLEAR_EN
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          // Address 0 is launched on the entering edge so the write lines up
          // with the first busy cycle; grants are blocked this cycle.
          if (clr_start) begin
            state    <= CLEAR;
            clr_busy <= 1'b1;
            clr_cnt  <= CNT_ONE;
            ram_we   <= 1'b1;
            ram_addr <= '0;
            ram_din  <= '0;
          end
        end
        CLEAR: begin
          if (clr_cnt == LAST_CNT) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
            clr_cnt  <= '0;
          end else begin
            ram_we   <= 1'b1;
            ram_addr <= clr_cnt[ADDR_WIDTH-1:0];
            ram_din  <= '0;
            clr_cnt  <= clr_cnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
`endif
    end
  end

endmodule
